// File: rtl/dec_mpp_multi.sv
// rtl/dec_mpp_multi.sv - pipelined midpoint-prediction reconstruction stage with per-component history
module dec_mpp_multi #(
    parameter int BITDEPTH = 8,
    parameter int NCOMP    = 3,
    parameter int RES_W    = 9
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [1:0]              in_comp,
    input  logic                    in_first,
    input  logic [3:0]              in_step,
    input  logic [16*RES_W-1:0]     in_res,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [1:0]              out_comp,
    output logic [16*BITDEPTH-1:0]  out_rec
);

    localparam int          MAXVAL = (1 << BITDEPTH) - 1;
    localparam int          MIDDLE = 1 << (BITDEPTH - 1);
    localparam logic [3:0]  SMAX   = 4'(BITDEPTH - 1);

    // stage-1 registers
    logic                   r_s1_vld;
    logic [1:0]             r_s1_comp;
    logic                   r_s1_first;
    logic [3:0]             r_s1_step;
    logic [16*RES_W-1:0]    r_s1_res;

    // stage-2 (output) registers
    logic                   r_out_vld;
    logic [1:0]             r_out_comp;
    logic [16*BITDEPTH-1:0] r_out_rec;

    // previous reconstructed block per component
    logic [16*BITDEPTH-1:0] r_hist [NCOMP];
    logic [NCOMP-1:0]       r_hvld;

    logic                   w_adv;
    logic                   w_comp_ok;
    logic                   w_use_mid;
    logic [16*BITDEPTH-1:0] w_hsel;
    logic                   w_hv;
    logic [16*BITDEPTH-1:0] w_rec;
    int                     w_s;
    int                     w_bias;
    int                     w_maxclip;
    int                     w_sum;
    int                     w_mean;
    int                     w_val;
    int                     w_mp [4];

    assign w_adv     = r_s1_vld && (!r_out_vld || out_rdy);
    assign in_rdy    = !r_s1_vld || w_adv;
    assign w_comp_ok = (int'(r_s1_comp) < NCOMP);
    assign out_vld   = r_out_vld;
    assign out_comp  = r_out_comp;
    assign out_rec   = r_out_rec;

    // pick the stored block and valid bit of the stage-1 component
    always_comb begin
        w_hsel = '0;
        w_hv   = 1'b0;
        for (int c = 0; c < NCOMP; c++) begin
            if (int'(r_s1_comp) == c) begin
                w_hsel = r_hist[c];
                w_hv   = r_hvld[c];
            end
        end
    end

    // midpoint per 2x2 subblock, dequantise residuals, add and saturate
    always_comb begin
        w_rec     = '0;
        w_sum     = 0;
        w_mean    = 0;
        w_val     = 0;
        w_s       = (r_s1_step > SMAX) ? int'(SMAX) : int'(r_s1_step);
        w_bias    = (w_s == 0) ? 0 : (1 << (w_s - 1));
        w_maxclip = MIDDLE + 2 * w_bias;
        if (w_maxclip > MAXVAL) w_maxclip = MAXVAL;
        w_use_mid = r_s1_first || !w_hv || !w_comp_ok;
        for (int j = 0; j < 4; j++) begin
            w_sum  = int'(w_hsel[(2*j)*BITDEPTH   +: BITDEPTH])
                   + int'(w_hsel[(2*j+1)*BITDEPTH +: BITDEPTH])
                   + int'(w_hsel[(2*j+8)*BITDEPTH +: BITDEPTH])
                   + int'(w_hsel[(2*j+9)*BITDEPTH +: BITDEPTH]);
            w_mean = w_use_mid ? MIDDLE : (w_sum >> 2);
            w_mp[j] = w_mean + 2 * w_bias;
            if (w_mp[j] < MIDDLE)    w_mp[j] = MIDDLE;
            if (w_mp[j] > w_maxclip) w_mp[j] = w_maxclip;
        end
        for (int i = 0; i < 16; i++) begin
            w_val = (int'($signed(r_s1_res[i*RES_W +: RES_W])) <<< w_s) + w_mp[(i % 8) / 2];
            if (w_val < 0)      w_val = 0;
            if (w_val > MAXVAL) w_val = MAXVAL;
            w_rec[i*BITDEPTH +: BITDEPTH] = BITDEPTH'(w_val);
        end
    end

    // stage 1: capture an accepted input beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld   <= 1'b0;
            r_s1_comp  <= '0;
            r_s1_first <= 1'b0;
            r_s1_step  <= '0;
            r_s1_res   <= '0;
        end else if (in_rdy) begin
            r_s1_vld <= in_vld;
            if (in_vld) begin
                r_s1_comp  <= in_comp;
                r_s1_first <= in_first;
                r_s1_step  <= in_step;
                r_s1_res   <= in_res;
            end
        end
    end

    // stage 2: output register, held until downstream accepts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_vld  <= 1'b0;
            r_out_comp <= '0;
            r_out_rec  <= '0;
        end else if (w_adv) begin
            r_out_vld  <= 1'b1;
            r_out_comp <= r_s1_comp;
            r_out_rec  <= w_rec;
        end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

    // history write on the same edge the beat enters stage 2
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCOMP; c++) r_hist[c] <= '0;
            r_hvld <= '0;
        end else if (w_adv && w_comp_ok) begin
            for (int c = 0; c < NCOMP; c++) begin
                if (int'(r_s1_comp) == c) begin
                    r_hist[c] <= w_rec;
                    r_hvld[c] <= 1'b1;
                end
            end
        end
    end

endmodule
